mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX/MEM slot holds a real instruction.
REQ-005 ex_wb  in  2  WB control: [1]=MemtoReg, [0]=RegWrite.
REQ-006 ex_memread / ex_memwrite  in  1 each  load / store.
REQ-007 ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ex_aluout  in  32  effective address or ALU result.
REQ-009 ex_rs2data  in  32  store data.
REQ-010 ex_rd  in  5  destination register.
REQ-011 mem_stall  out  1  holds IF..EX/MEM when high.
REQ-012 dm_req  out  1  data-memory request; dm_gnt in 1 accepts it.
REQ-013 dm_we  out  1 / dm_wstrb  out  4 / dm_addr  out  32 / dm_wdata  out  32  request payload.
REQ-014 dm_rvalid  in  1 / dm_rdata  in  32  response (loads and stores).
REQ-015 wb_valid out 1 / WB out 2 / memout out 32 / aluout out 32 / wb_rd out 5  MEM/WB register feeding WB stage.
REQ-016 mem_misalign  out  1  one-cycle pulse on misaligned access.

Function
REQ-017 FSM states IDLE, REQ, WAIT; memop = ex_valid & (ex_memread | ex_memwrite).
REQ-018 IDLE, memop, aligned: latch address/data/funct3/wb/rd/we; go REQ; nothing written to MEM/WB.
REQ-019 REQ: dm_req=1 with stable payload until dm_gnt=1; on gnt go WAIT.
REQ-020 WAIT: on dm_rvalid=1 load MEM/WB (wb_valid=1), go IDLE; otherwise stay.
REQ-021 dm_req SHALL be 0 in IDLE and WAIT; dm_rvalid outside WAIT and dm_gnt outside REQ ignored.
REQ-022 mem_stall = (IDLE & memop) | REQ | (WAIT & !dm_rvalid), combinational.
REQ-023 Non-memory valid instruction in IDLE: MEM/WB loaded next edge, latency 1, memout=0, mem_stall=0.
REQ-024 ex_valid=0 in IDLE, or any cycle MEM/WB is not loaded: wb_valid=0, WB=00 next edge (bubble).
REQ-025 dm_addr = {addr[31:2],2'b00}; aluout passes the unmodified address.
REQ-026 Store: SB wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH wstrb=0011/1100 by addr[1], wdata={2{rs2[15:0]}}; SW wstrb=1111; dm_we=1.
REQ-027 Load: dm_we=0, wstrb=0000; byte/half picked from dm_rdata by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W raw; result to memout.
REQ-028 Store completion: memout=0, WB=latched ex_wb.
REQ-029 Misaligned (H with addr[0]=1; W with addr[1:0]!=0): no request, stays IDLE, mem_stall=0, next edge wb_valid=1, WB=00, mem_misalign=1 one cycle.
REQ-030 ex_memread and ex_memwrite both high: treated as store.
REQ-031 Back-to-back memory ops: completion edge returns to IDLE; next op captured the following cycle (min 3 cycles/op with gnt and rvalid each one cycle after entry).

Reset
REQ-032 rst=1 immediately forces IDLE, dm_req=0, dm_we=0, dm_wstrb=0, dm_addr=0, dm_wdata=0, mem_stall=0, wb_valid=0, WB=00, memout=0, aluout=0, wb_rd=0, mem_misalign=0.
REQ-033 Reset mid-REQ/WAIT abandons the access; a dm_rvalid after release is ignored.

Verification
REQ-034 ADD, aluout=0x1234, rd=5, wb=01 -> next edge wb_valid=1, WB=01, aluout=0x1234, wb_rd=5, mem_stall never high.
REQ-035 LB addr=0x103, rdata=0x80FF_FF7F, gnt 2 cycles late -> dm_req held 3 cycles, dm_addr=0x100, memout=0xFFFF_FF80, WB=11.
REQ-036 SH addr=0x202, rs2=0xAAAA_BEEF -> dm_we=1, wstrb=1100, wdata=0xBEEF_BEEF, memout=0, stall until rvalid.
REQ-037 LW addr=0x301 -> dm_req stays 0, mem_misalign pulses once, WB=00, wb_valid=1.
REQ-038 LHU addr=0x402, rdata=0x9ABC_1234 -> memout=0x0000_9ABC; then rst in WAIT, late rvalid -> stays IDLE, wb_valid=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a request/grant/response data-memory port,
// byte/half/word access shaping and the MEM/WB pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  ex_wb,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_rs2data,
    input  logic [4:0]  ex_rd,
    output logic        mem_stall,
    output logic        dm_req,
    input  logic        dm_gnt,
    output logic        dm_we,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [1:0]  wb,
    output logic [31:0] memout,
    output logic [31:0] aluout,
    output logic [4:0]  wb_rd,
    output logic        mem_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_f3;
    logic [1:0]  r_wb;
    logic [4:0]  r_rd;
    logic        r_we;
    logic        w_memop;
    logic        w_mis;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [15:0] w_lane;
    logic [31:0] w_load;

    assign w_memop = ex_valid & (ex_memread | ex_memwrite);
    assign w_mis = ((ex_funct3[1:0] == 2'b01) & ex_aluout[0]) |
                   ((ex_funct3[1:0] == 2'b10) & (ex_aluout[1:0] != 2'b00));
    assign w_wstrb = (ex_funct3[1:0] == 2'b00) ? (4'b0001 << ex_aluout[1:0]) :
                     (ex_funct3[1:0] == 2'b01) ? (ex_aluout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = (ex_funct3[1:0] == 2'b00) ? {4{ex_rs2data[7:0]}} :
                     (ex_funct3[1:0] == 2'b01) ? {2{ex_rs2data[15:0]}} : ex_rs2data;
    // selected byte/half lands in the low bits of w_lane
    assign w_lane = 16'(dm_rdata >> {r_addr[1:0], 3'b000});
    assign w_load = (r_f3 == 3'b000) ? {{24{w_lane[7]}}, w_lane[7:0]} :
                    (r_f3 == 3'b001) ? {{16{w_lane[15]}}, w_lane} :
                    (r_f3 == 3'b100) ? {24'b0, w_lane[7:0]} :
                    (r_f3 == 3'b101) ? {16'b0, w_lane} : dm_rdata;
    assign dm_req = (r_state == REQ);
    assign mem_stall = ~rst & (((r_state == IDLE) & w_memop & ~w_mis) | (r_state == REQ) |
                               ((r_state == WAIT) & ~dm_rvalid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_f3         <= '0;
            r_wb         <= '0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            dm_we        <= 1'b0;
            dm_wstrb     <= '0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            wb_valid     <= 1'b0;
            wb           <= '0;
            memout       <= '0;
            aluout       <= '0;
            wb_rd        <= '0;
            mem_misalign <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb           <= '0;
            mem_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_memop && !w_mis) begin
                        r_addr   <= ex_aluout;
                        r_f3     <= ex_funct3;
                        r_wb     <= ex_wb;
                        r_rd     <= ex_rd;
                        r_we     <= ex_memwrite;
                        dm_we    <= ex_memwrite;
                        dm_wstrb <= ex_memwrite ? w_wstrb : 4'b0000;
                        dm_addr  <= {ex_aluout[31:2], 2'b00};
                        dm_wdata <= ex_memwrite ? w_wdata : 32'b0;
                        r_state  <= REQ;
                    end else if (ex_valid) begin
                        wb_valid     <= 1'b1;
                        wb           <= w_memop ? 2'b00 : ex_wb;
                        mem_misalign <= w_memop;
                        memout       <= '0;
                        aluout       <= ex_aluout;
                        wb_rd        <= ex_rd;
                    end
                end
                REQ: if (dm_gnt) r_state <= WAIT;
                WAIT: begin
                    if (dm_rvalid) begin
                        wb_valid <= 1'b1;
                        wb       <= r_wb;
                        memout   <= r_we ? 32'b0 : w_load;
                        aluout   <= r_addr;
                        wb_rd    <= r_rd;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
